// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master: loader side (consumes stream, drives imem); slave: host/memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: byte stream -> count N, N little-endian words into imem,
// then releases core_rst. Ports: clk, rst (sync, active-high), bus
// (prog_loader_if.master: in_data/in_valid/in_ready, imem_we/addr/wdata),
// core_rst, done, error. Optional trailing checksum byte enabled by
// defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus,
  output logic          core_rst,
  output logic          done,
  output logic          error
);
  localparam logic [2:0] CNT_LO = 3'd0;
  localparam logic [2:0] CNT_HI = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM   = 3'd5;
  localparam logic [2:0] FIN    = CSUM;
`else
  localparam logic [2:0] FIN    = RUN;
`endif
  localparam logic [16:0] MAXN = 17'(1) << ADDR_W;

  logic [2:0]        r_state;
  logic [15:0]       r_cnt;
  logic [15:0]       r_idx;
  logic [1:0]        r_byte;
  logic [23:0]       r_part;
  logic              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic        w_st_rdy;
  logic        w_ready;
  logic        w_acc;
  logic [15:0] w_n;
  logic        w_big;
  logic        w_last;

  always_comb begin
    w_st_rdy = 1'b0;
    case (r_state)
      CNT_LO:  w_st_rdy = 1'b1;
      CNT_HI:  w_st_rdy = 1'b1;
      // final word already taken: only the write pulse remains
      DATA:    w_st_rdy = !r_last;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:    w_st_rdy = 1'b1;
`endif
      default: w_st_rdy = 1'b0;
    endcase
  end

  assign w_ready = w_st_rdy & !rst;
  assign w_acc   = bus.in_valid & w_ready;
  assign w_n     = {bus.in_data, r_cnt[7:0]};
  assign w_big   = {1'b0, w_n} > MAXN;
  assign w_last  = (r_idx == r_cnt - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CNT_LO;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_part  <= '0;
      r_last  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        CNT_LO: if (w_acc) begin
          r_cnt[7:0] <= bus.in_data;
          r_state    <= CNT_HI;
        end
        CNT_HI: if (w_acc) begin
          r_cnt <= w_n;
          if (w_big)
            r_state <= ERR;
          else if (w_n == 16'd0)
            r_state <= FIN;
          else
            r_state <= DATA;
        end
        DATA: begin
          if (r_last) begin
            r_state <= RUN;
          end else if (w_acc) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum <= r_sum + bus.in_data;
`endif
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_idx[ADDR_W-1:0];
              r_wdata <= {bus.in_data, r_part};
              r_idx   <= r_idx + 16'd1;
              if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                r_state <= CSUM;
`else
                r_last  <= 1'b1;
`endif
              end
            end else begin
              r_part[{r_byte, 3'b000} +: 8] <= bus.in_data;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM: if (w_acc) begin
          r_state <= (bus.in_data == r_sum) ? RUN : ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;

  assign done     = (r_state == RUN);
  assign error    = (r_state == ERR);
  assign core_rst = (r_state != RUN);
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  8  loader byte stream.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-007 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-008 SHALL have port imem_addr  output  ADDR_W  word address of write.
REQ-009 SHALL have port imem_wdata  output  32  instruction word written.
REQ-010 SHALL have port core_rst  output  1  reset driven to the processor top level, active-high.
REQ-011 SHALL have port done  output  1  program loaded, core running.
REQ-012 SHALL have port error  output  1  load aborted.

Function
REQ-013 SHALL accept a byte only on a rising edge where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-014 SHALL implement states CNT_LO, CNT_HI, DATA, CSUM, RUN, ERR; CSUM exists only per REQ-028.
REQ-015 SHALL take the first two accepted bytes as 16-bit word count N, little-endian (CNT_LO, then CNT_HI).
REQ-016 SHALL, on leaving CNT_HI, go to ERR if N > 2^ADDR_W, to CSUM/RUN if N = 0, else to DATA.
REQ-017 SHALL assemble each 4 DATA bytes little-endian (first byte = bits 7:0) into one word.
REQ-018 SHALL pulse imem_we for exactly one cycle, the cycle after the 4th byte of a word is accepted, with imem_addr = word index (0,1,2,...) and imem_wdata = assembled word.
REQ-019 SHALL hold in_ready = 1 in CNT_LO, CNT_HI, DATA, CSUM and 0 in RUN and ERR; writes never stall the stream.
REQ-020 SHALL hold imem_addr and imem_wdata stable while imem_we = 0, and SHALL never assert imem_we outside DATA-word completion.
REQ-021 SHALL leave DATA after the N-th word: to CSUM if enabled, else to RUN, entering RUN no earlier than the cycle after the final imem_we pulse.
REQ-022 SHALL drive core_rst = 1 in every state except RUN, and done = 1 only in RUN.
REQ-023 SHALL drive error = 1 only in ERR; RUN and ERR are terminal until rst.

Reset
REQ-024 SHALL, with rst = 1 at a rising edge, set state CNT_LO, word index 0, byte counter 0, partial word cleared, checksum accumulator 0.
REQ-025 SHALL have output reset values: in_ready 0 during rst, 1 thereafter; imem_we 0; imem_addr 0; imem_wdata 0; core_rst 1; done 0; error 0.
REQ-026 SHALL, on reset mid-load, discard the partial word without writing it; previously written memory contents are untouched.
REQ-027 SHALL give rst priority over any simultaneous byte acceptance.

Configuration
REQ-028 SHALL, with macro PROG_LOADER_CHECKSUM_EN defined, accumulate the 8-bit sum (mod 256) of all DATA bytes and expect one trailing byte in CSUM: equal -> RUN, unequal -> ERR (core stays in reset).
REQ-029 SHALL, without PROG_LOADER_CHECKSUM_EN, omit CSUM and the accumulator; DATA (or N = 0) goes directly to RUN; ERR is reachable only via REQ-016.

Verification
REQ-030 SHALL cover stream 02 00 13 00 10 00 93 00 20 00 [D6 if checksum] -> imem_we twice: addr 0 = 0x00100013, addr 1 = 0x00200093; then core_rst 0, done 1, in_ready 0.
REQ-031 SHALL cover REQ-030 with in_valid low on alternate cycles -> identical writes and final state.
REQ-032 SHALL cover N = 0 (00 00 [00]) -> no imem_we, RUN reached, core_rst 0.
REQ-033 SHALL cover N = 257 with ADDR_W = 8 (01 01) -> ERR, error 1, core_rst 1, in_ready 0, no imem_we.
REQ-034 SHALL cover REQ-030 stream with checksum D7 (macro defined) -> both words written, then error 1, core_rst 1, done 0.
REQ-035 SHALL cover rst after 5 DATA-phase bytes of REQ-030, then full REQ-030 stream -> no write of the partial word, final result as REQ-030.
